// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sequencing NUM_REQ requesters onto one I2C master
// Optional WAIT-state watchdog with master abort is built when I2C_ARB_TIMEOUT_EN is defined.
module i2c_txn_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]           req_rw,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_LEN-1:0]          rsp_rdata,
  output logic                         rsp_err,
  output logic                         m_start,
  output logic [ADDR_LEN-1:0]          m_addr,
  output logic                         m_rw,
  output logic [DATA_LEN-1:0]          m_wdata,
  output logic                         m_abort,
  input  logic                         m_busy,
  input  logic                         m_done,
  input  logic                         m_ack_err,
  input  logic [DATA_LEN-1:0]          m_rdata
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("i2c_txn_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        ptr, ptr_n, gidx, gidx_n, win, cand;
  logic                 win_vld;
  logic [NUM_REQ-1:0]   gnt_n, rsp_valid_n;
  logic [DATA_LEN-1:0]  rsp_rdata_n, m_wdata_n;
  logic [ADDR_LEN-1:0]  m_addr_n;
  logic                 rsp_err_n, m_start_n, m_rw_n;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0]          cnt, cnt_n;
  logic                 m_abort_n;
`endif

  // First requesting index after ptr, wrapping; the last winner ends up lowest priority.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gidx_n      = gidx;
    gnt_n       = gnt;
    m_start_n   = m_start;
    m_addr_n    = m_addr;
    m_rw_n      = m_rw;
    m_wdata_n   = m_wdata;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_n       = cnt;
    m_abort_n   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        gnt_n     = '0;
        m_start_n = 1'b0;
        if (win_vld) begin
          gidx_n    = win;
          gnt_n     = NUM_REQ'(1) << win;
          m_addr_n  = req_addr[win*ADDR_LEN +: ADDR_LEN];
          m_rw_n    = req_rw[win];
          m_wdata_n = req_wdata[win*DATA_LEN +: DATA_LEN];
          m_start_n = 1'b1;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_busy) begin
          m_start_n = 1'b0;
          if (m_done) begin
            rsp_valid_n = gnt;
            rsp_rdata_n = m_rw ? m_rdata : '0;
            rsp_err_n   = m_ack_err;
            state_n     = S_DONE;
          end else begin
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_n = '0;
`endif
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (m_done) begin
          rsp_valid_n = gnt;
          rsp_rdata_n = m_rw ? m_rdata : '0;
          rsp_err_n   = m_ack_err;
          state_n     = S_DONE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        // Counting this cycle, TIMEOUT WAIT cycles have elapsed; a same-cycle m_done wins above.
        else if (cnt + 16'd1 == 16'(TIMEOUT)) begin
          m_abort_n   = 1'b1;
          rsp_valid_n = gnt;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b1;
          state_n     = S_DONE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
`endif
      end
      S_DONE: begin
        ptr_n   = gidx;
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= PW'(NUM_REQ - 1);
      gidx      <= '0;
      gnt       <= '0;
      m_start   <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_wdata   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      gnt       <= gnt_n;
      m_start   <= m_start_n;
      m_addr    <= m_addr_n;
      m_rw      <= m_rw_n;
      m_wdata   <= m_wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      m_abort <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      m_abort <= m_abort_n;
    end
  end
`else
  assign m_abort = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - scoreboard bench for i2c_txn_arbiter with a behavioural I2C master
module tb_i2c_txn_arbiter;
  localparam int N = 4;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int NORM_DLY = 15;
`else
  localparam int NORM_DLY = 40;
`endif

  logic            clk, rst;
  logic [N-1:0]    req, req_rw, gnt, rsp_valid;
  logic [N*7-1:0]  req_addr;
  logic [N*8-1:0]  req_wdata;
  logic [7:0]      rsp_rdata, m_wdata, m_rdata;
  logic [6:0]      m_addr;
  logic            rsp_err, m_start, m_rw, m_abort, m_busy, m_done, m_ack_err;

  i2c_txn_arbiter #(.NUM_REQ(N), .ADDR_LEN(7), .DATA_LEN(8), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
    .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic [6:0]   addr;
    logic         rw;
    logic [7:0]   wdata;
    logic         err;
    logic [7:0]   rdata;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Master model: busy two cycles after start, done after mdl_delay busy cycles.
  logic       mdl_hang = 1'b0, mdl_err = 1'b0;
  logic [7:0] mdl_rdata = 8'h00;
  int         mdl_delay = NORM_DLY;
  int         ms, mc;
  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00; ms = 0; mc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00; ms = 0;
      end else begin
        case (ms)
          0: if (m_start) begin ms = 1; mc = 0; end
          1: begin
            mc++;
            if (mc == 2) begin m_busy = 1'b1; ms = 2; mc = 0; end
          end
          2: begin
            if (m_abort) begin
              m_busy = 1'b0; ms = 0;
            end else begin
              mc++;
              if (!mdl_hang && mc == mdl_delay) begin
                m_done = 1'b1; m_ack_err = mdl_err; m_rdata = mdl_rdata; ms = 3;
              end
            end
          end
          default: begin
            m_done = 1'b0; m_busy = 1'b0; m_ack_err = 1'b0; m_rdata = 8'h00; ms = 0;
          end
        endcase
      end
    end
  end

  // Monitor: compares issue fields and responses against the scoreboard queue.
  int   cyc = 0, gnt_cnt = 0, grant_cyc = 0, abort_cnt = 0, abort_cyc = 0;
  logic start_prev = 1'b0, busy_prev = 1'b0, rsp_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        start_prev = 1'b0; busy_prev = 1'b0; rsp_prev = 1'b0;
        exp_q.delete();
      end else begin
        if (m_abort) begin abort_cnt++; abort_cyc = cyc; end
        if (m_start && !start_prev) begin gnt_cnt++; grant_cyc = cyc; end
        if (m_start) begin
          if (exp_q.size() == 0) chk("unexp_gnt", 64'(gnt), 64'(0));
          else chk("issue", 64'({gnt, m_addr, m_rw, m_wdata}),
                   64'({exp_q[0].gnt, exp_q[0].addr, exp_q[0].rw, exp_q[0].wdata}));
        end
        if (m_busy && !busy_prev) chk("start_clr", 64'(m_start), 64'(0));
        if (rsp_prev) chk("gnt_clr", 64'(gnt), 64'(0));
        if (m_done || rsp_valid != '0) begin
          if (exp_q.size() == 0) chk("unexp_rsp", 64'(rsp_valid), 64'(0));
          else begin
            e = exp_q.pop_front();
            chk("rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({e.gnt, e.err, e.rdata}));
          end
        end
        start_prev = m_start;
        busy_prev  = m_busy;
        rsp_prev   = (rsp_valid != '0);
      end
    end
  end

  logic [N-1:0] hold = '0;
  // Requesters without hold drop their request once they see their response.
  task automatic tick();
    @(posedge clk); #2;
    for (int i = 0; i < N; i++)
      if (rsp_valid[i] === 1'b1 && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic set_fields(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic push_exp(input int i, input logic err, input logic [7:0] rd);
    exp_t e;
    e.gnt   = N'(1) << i;
    e.addr  = req_addr[i*7 +: 7];
    e.rw    = req_rw[i];
    e.wdata = req_wdata[i*8 +: 8];
    e.err   = err;
    e.rdata = req_rw[i] ? rd : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (gnt_cnt < n && t < 3000) begin tick(); t++; end
    chk("wait_gnt", 64'(gnt_cnt), 64'(n));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || gnt != '0) && t < 3000) begin tick(); t++; end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, a0;
    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_out", 64'({gnt, rsp_valid, rsp_rdata, rsp_err, m_start, m_addr, m_rw, m_wdata, m_abort}), 64'(0));
    rst = 1'b0;
    tick();

    // Single write from requester 0; the model offers read data that must be masked.
    set_fields(0, 7'h50, 1'b0, 8'hA5);
    mdl_rdata = 8'hFF; mdl_err = 1'b0;
    push_exp(0, 1'b0, 8'h00);
    req = 4'b0001;
    tick();
    chk("lat_gnt", 64'({gnt, m_start}), 64'({4'b0001, 1'b1}));
    wait_drain();

    // Read with NACK from requester 3.
    set_fields(3, 7'h6C, 1'b1, 8'h00);
    mdl_rdata = 8'h3C; mdl_err = 1'b1;
    push_exp(3, 1'b1, 8'h3C);
    req[3] = 1'b1;
    wait_drain();

    // Round-robin with 0 and 2 held, then requester 1 joins while 2 is granted.
    for (int i = 0; i < 3; i++) set_fields(i, 7'(8'h10 + i), 1'b0, 8'(8'h20 + i));
    mdl_rdata = 8'hFF; mdl_err = 1'b0;
    push_exp(0, 1'b0, 8'h00); push_exp(2, 1'b0, 8'h00);
    push_exp(0, 1'b0, 8'h00); push_exp(2, 1'b0, 8'h00);
    hold = 4'b0101;
    g0 = gnt_cnt;
    req = 4'b0101;
    wait_grants(g0 + 4);
    req[1] = 1'b1;
    push_exp(0, 1'b0, 8'h00); push_exp(1, 1'b0, 8'h00); push_exp(2, 1'b0, 8'h00);
    wait_grants(g0 + 7);
    req[0] = 1'b0;
    hold = '0;
    wait_drain();

`ifdef I2C_ARB_TIMEOUT_EN
    // Completion on the TIMEOUT-th WAIT cycle beats the watchdog.
    set_fields(3, 7'h22, 1'b0, 8'h5E);
    mdl_delay = 20; mdl_err = 1'b0;
    push_exp(3, 1'b0, 8'h00);
    a0 = abort_cnt;
    req[3] = 1'b1;
    wait_drain();
    chk("tmo_edge_noabort", 64'(abort_cnt), 64'(a0));

    // Master never completes: abort plus error response, read data zeroed.
    set_fields(2, 7'h41, 1'b1, 8'h00);
    mdl_hang = 1'b1; mdl_rdata = 8'h77;
    push_exp(2, 1'b1, 8'h00);
    req[2] = 1'b1;
    wait_drain();
    chk("tmo_abort_cnt", 64'(abort_cnt), 64'(a0 + 1));
    chk("tmo_abort_at", 64'(abort_cyc - grant_cyc), 64'(23));
    mdl_hang = 1'b0; mdl_delay = NORM_DLY;
`else
    a0 = 0;
`endif

    // Reset during WAIT with requester 1 granted and requester 2 waiting.
    set_fields(1, 7'h19, 1'b0, 8'h66);
    push_exp(1, 1'b0, 8'h00);
    g0 = gnt_cnt;
    req[1] = 1'b1;
    wait_grants(g0 + 1);
    repeat (12) tick();
    set_fields(2, 7'h2B, 1'b0, 8'h99);
    req[2] = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_mid", 64'({gnt, rsp_valid, m_start, m_abort}), 64'(0));
    set_fields(1, 7'h19, 1'b1, 8'h00);
    mdl_rdata = 8'h5A; mdl_err = 1'b0;
    push_exp(1, 1'b0, 8'h5A);
    push_exp(2, 1'b0, 8'h00);
    rst = 1'b0;
    wait_drain();

`ifndef I2C_ARB_TIMEOUT_EN
    chk("no_abort", 64'(abort_cnt), 64'(a0));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
